leds_pwm: RTL and testbench
===========================

Name: leds_pwm

Overview:
- Parametrised successor of the single-register Avalon-MM LED output port.
- Drives NUM_LEDS LED lines from a small Avalon-MM slave register file.
- Adds readback, atomic set/clear, a per-LED blink mask with a programmable blink timer, and a global PWM brightness.
- Sits on the system interconnect next to the other user I/O peripherals; user_dataout_0 goes to board pins.

Parameters:
- NUM_LEDS, 8, number of LED outputs (1..32).
- PWM_BITS, 8, PWM counter width; the PWM period is 2^PWM_BITS cycles.
- PRESCALE_BITS, 24, blink timer width (<=32).
- BLINK_DEFAULT, 24'd12_499_999, reset value of BLINK_RELOAD.

Ports:
- csi_clk  in  1  single clock; all logic on its rising edge.
- csi_reset  in  1  synchronous, active-high reset.
- avs_s1_address  in  4  word address.
- avs_s1_write  in  1  write strobe.
- avs_s1_writedata  in  32  write data.
- avs_s1_read  in  1  read strobe.
- avs_s1_readdata  out  32  read data; fixed read latency of 1 cycle.
- user_dataout_0  out  NUM_LEDS  registered LED drive.

Behaviour:
- Reset: sampled at the csi_clk edge, synchronous, active-high. Takes priority over any access in the same cycle, including mid-blink and mid-PWM-period. Reset values:
  - DATA=0, MASK=0, BLINK_RELOAD=BLINK_DEFAULT, DUTY=2^PWM_BITS (full on).
  - blink counter=0, phase=1, PWM counter=0.
  - user_dataout_0=0, avs_s1_readdata=0.
- Register map (unused high writedata bits ignored; unused high readdata bits read as 0):
  - 0x0 DATA rw [NUM_LEDS-1:0]: direct LED values.
  - 0x1 SET wo: DATA <= DATA | wdata. Reads return DATA.
  - 0x2 CLR wo: DATA <= DATA & ~wdata. Reads return DATA.
  - 0x3 MASK rw: a 1 makes that LED blink.
  - 0x4 BLINK_RELOAD rw [PRESCALE_BITS-1:0].
  - 0x5 DUTY rw [PWM_BITS:0]: values >= 2^PWM_BITS mean always on; 0 means always off.
  - 0x6-0xF: writes ignored, reads 0.
- Write: a register updates at the edge where avs_s1_write=1. user_dataout_0 reflects the new value one edge later, so the write-to-pin latency is 2 edges.
- Read: avs_s1_readdata is registered at the edge where avs_s1_read=1 and held until the next read.
  - Read and write in the same cycle: the write commits and readdata returns the pre-write value.
- Blink timer:
  - Counter increments every cycle. When count==BLINK_RELOAD, count<=0 and phase toggles, so a half-period is BLINK_RELOAD+1 cycles.
  - BLINK_RELOAD=0 toggles every cycle.
  - A write to BLINK_RELOAD forces count<=0 and phase<=1 in the same edge.
  - Lowering BLINK_RELOAD below the current count is safe, because the write resets the counter.
- PWM: counter runs freely 0..2^PWM_BITS-1 and wraps to 0. pwm_on = (pwm_cnt < DUTY), compared at PWM_BITS+1 width.
- Output, each edge: user_dataout_0 <= DATA & (~MASK | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}}.
- Default-after-reset behaviour matches a plain LED register: full duty, no blink, writing DATA drives the pins.

Decomposition:
- Package leds_pkg: register address constants (ADDR_DATA..ADDR_DUTY) and the readdata width constant.
- One sub-module, leds_blink_timer (PRESCALE_BITS):
  - inputs: clk, reset, reload value, reload_wr.
  - output: phase.
- PWM counter, register file and output mux stay in leds_pwm.

Test Plan:
- Reset, then write DATA=0xA5 at edge k -> user_dataout_0=0xA5 from edge k+1 onward; a read of 0x0 returns 0x000000A5.
- DATA=0xF0, write SET=0x0F, then CLR=0x81 -> DATA reads 0x7E and pins show 0x7E. Reads of 0x1/0x2 also return 0x7E.
- BLINK_RELOAD=3, MASK=0x01, DATA=0x03 -> bit0 is high 4 cycles, low 4 cycles, repeating; bit1 is constantly high. Rewriting RELOAD mid-period restarts with phase=1.
- PWM_BITS=8, DUTY=64, DATA=0xFF -> pins are 0xFF for exactly 64 of every 256 cycles. DUTY=0 -> pins constantly 0. DUTY=256 -> pins constantly 0xFF.
- Assert csi_reset mid-blink with a write in the same cycle -> the write is discarded, all registers and outputs take reset values at that edge, and blink phase=1.
- Write to 0x9, then read 0x9 -> no register changes and readdata=0. A simultaneous read+write of DATA returns the old DATA value.

Source files
------------

// File: rtl/leds_pkg.sv
// Shared constants for the LED/PWM register file: word addresses and bus width.
package leds_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_SET    = 4'h1;
    localparam logic [3:0] ADDR_CLR    = 4'h2;
    localparam logic [3:0] ADDR_MASK   = 4'h3;
    localparam logic [3:0] ADDR_RELOAD = 4'h4;
    localparam logic [3:0] ADDR_DUTY   = 4'h5;

    localparam int RDATA_W = 32;

endpackage

// File: rtl/leds_blink_timer.sv
// Free-running blink prescaler: phase toggles every reload_i+1 cycles and
// restarts high whenever a new reload value is written.
module leds_blink_timer #(
    parameter int PRESCALE_BITS = 24
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [PRESCALE_BITS-1:0] reload_i,
    input  logic                     reload_wr_i,
    output logic                     phase_o
);

    logic [PRESCALE_BITS-1:0] count_q, count_d;
    logic                     phase_q, phase_d;

    always_comb begin
        count_d = count_q + PRESCALE_BITS'(1);
        phase_d = phase_q;
        // A reload write restarts the half-period, so shrinking reload below count is harmless.
        if (reload_wr_i) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (count_q == reload_i) begin
            count_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            phase_q <= 1'b1;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/leds_pwm.sv
// Avalon-MM LED port with readback, atomic set/clear, per-LED blink and
// global PWM brightness. Read latency is one cycle; pins are registered.
module leds_pwm
    import leds_pkg::*;
#(
    parameter int                       NUM_LEDS      = 8,
    parameter int                       PWM_BITS      = 8,
    parameter int                       PRESCALE_BITS = 24,
    parameter logic [PRESCALE_BITS-1:0] BLINK_DEFAULT = PRESCALE_BITS'(12_499_999)
) (
    input  logic                csi_clk,
    input  logic                csi_reset,
    input  logic [3:0]          avs_s1_address,
    input  logic                avs_s1_write,
    input  logic [31:0]         avs_s1_writedata,
    input  logic                avs_s1_read,
    output logic [31:0]         avs_s1_readdata,
    output logic [NUM_LEDS-1:0] user_dataout_0
);

    localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

    logic [NUM_LEDS-1:0]      data_q, data_d;
    logic [NUM_LEDS-1:0]      mask_q, mask_d;
    logic [PRESCALE_BITS-1:0] reload_q, reload_d;
    logic [PWM_BITS:0]        duty_q, duty_d;
    logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0]      dout_q, dout_d;
    logic [RDATA_W-1:0]       rdata_q, rdata_d;

    logic                     reload_wr;
    logic                     phase;
    logic                     pwm_on;
    logic [NUM_LEDS-1:0]      wdata_leds;
    logic                     unused_wdata;

    assign wdata_leds   = avs_s1_writedata[NUM_LEDS-1:0];
    assign unused_wdata = ^avs_s1_writedata;
    assign reload_wr    = avs_s1_write && (avs_s1_address == ADDR_RELOAD);

    leds_blink_timer #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_blink (
        .clk_i       (csi_clk),
        .reset_i     (csi_reset),
        .reload_i    (reload_q),
        .reload_wr_i (reload_wr),
        .phase_o     (phase)
    );

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        reload_d = reload_q;
        duty_d   = duty_q;
        if (avs_s1_write) begin
            case (avs_s1_address)
                ADDR_DATA:   data_d   = wdata_leds;
                ADDR_SET:    data_d   = data_q | wdata_leds;
                ADDR_CLR:    data_d   = data_q & ~wdata_leds;
                ADDR_MASK:   mask_d   = wdata_leds;
                ADDR_RELOAD: reload_d = avs_s1_writedata[PRESCALE_BITS-1:0];
                ADDR_DUTY:   duty_d   = avs_s1_writedata[PWM_BITS:0];
                default:     ;
            endcase
        end
    end

    // Readback uses pre-write register values, so a same-cycle read+write returns old data.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_s1_read) begin
            case (avs_s1_address)
                ADDR_DATA, ADDR_SET, ADDR_CLR: rdata_d = RDATA_W'(data_q);
                ADDR_MASK:                     rdata_d = RDATA_W'(mask_q);
                ADDR_RELOAD:                   rdata_d = RDATA_W'(reload_q);
                ADDR_DUTY:                     rdata_d = RDATA_W'(duty_q);
                default:                       rdata_d = '0;
            endcase
        end
    end

    assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    assign pwm_on    = ({1'b0, pwm_cnt_q} < duty_q);
    assign dout_d    = data_q & (~mask_q | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}};

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            data_q    <= '0;
            mask_q    <= '0;
            reload_q  <= BLINK_DEFAULT;
            duty_q    <= DUTY_FULL;
            pwm_cnt_q <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
        end else begin
            data_q    <= data_d;
            mask_q    <= mask_d;
            reload_q  <= reload_d;
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs_s1_readdata = rdata_q;
    assign user_dataout_0  = dout_q;

endmodule

// File: tb/tb_leds_pwm.sv
// Bench for leds_pwm: directed scenarios with literal expectations, then random
// bus traffic checked cycle-by-cycle against an arithmetic model of the port.
module tb_leds_pwm;

    localparam int          NUM_LEDS   = 8;
    localparam int          PWM_BITS   = 8;
    localparam int          PRESCALE_W = 24;
    localparam int          PWM_PERIOD = 256;
    localparam int unsigned BLINK_DEF  = 12_499_999;

    logic        csi_clk = 1'b0;
    logic        csi_reset;
    logic [3:0]  avs_s1_address;
    logic        avs_s1_write;
    logic [31:0] avs_s1_writedata;
    logic        avs_s1_read;
    logic [31:0] avs_s1_readdata;
    logic [7:0]  user_dataout_0;

    int tests = 0;
    int fails = 0;

    always #5 csi_clk = ~csi_clk;

    leds_pwm #(
        .NUM_LEDS      (NUM_LEDS),
        .PWM_BITS      (PWM_BITS),
        .PRESCALE_BITS (PRESCALE_W)
    ) dut (
        .csi_clk          (csi_clk),
        .csi_reset        (csi_reset),
        .avs_s1_address   (avs_s1_address),
        .avs_s1_write     (avs_s1_write),
        .avs_s1_writedata (avs_s1_writedata),
        .avs_s1_read      (avs_s1_read),
        .avs_s1_readdata  (avs_s1_readdata),
        .user_dataout_0   (user_dataout_0)
    );

    // Model: register contents plus two elapsed-edge counters; blink phase and
    // PWM position are derived from them arithmetically.
    logic [31:0] m_data, m_mask, m_reload, m_duty;
    longint      m_edges;
    longint      m_since;
    logic [7:0]  m_pins;
    logic [31:0] m_rdata;
    logic [39:0] exp_q[$];

    function automatic logic [31:0] reg_value(input logic [3:0] a);
        case (a)
            4'h0, 4'h1, 4'h2: return m_data;
            4'h3:             return m_mask;
            4'h4:             return m_reload;
            4'h5:             return m_duty;
            default:          return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic wr, input logic rd,
                              input logic [3:0] addr, input logic [31:0] wdata);
        logic phase;
        logic pwm_on;
        if (rst) begin
            m_data   = 32'h0;
            m_mask   = 32'h0;
            m_reload = BLINK_DEF;
            m_duty   = 32'd256;
            m_edges  = 0;
            m_since  = 0;
            m_pins   = 8'h00;
            m_rdata  = 32'h0;
        end else begin
            phase  = ((m_since / (longint'(m_reload) + 1)) % 2) == 0;
            pwm_on = longint'(m_edges % PWM_PERIOD) < longint'(m_duty);
            m_pins = m_data[7:0] & (~m_mask[7:0] | {8{phase}}) & {8{pwm_on}};
            if (rd) m_rdata = reg_value(addr);
            m_edges++;
            m_since++;
            if (wr) begin
                case (addr)
                    4'h0: m_data   = wdata & 32'hFF;
                    4'h1: m_data   = (m_data | wdata) & 32'hFF;
                    4'h2: m_data   = m_data & ~wdata & 32'hFF;
                    4'h3: m_mask   = wdata & 32'hFF;
                    4'h4: begin
                        m_reload = wdata & 32'hFF_FFFF;
                        m_since  = 0;
                    end
                    4'h5: m_duty   = wdata & 32'h1FF;
                    default: ;
                endcase
            end
        end
        exp_q.push_back({m_rdata, m_pins});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: one expectation per clock edge, checked 1ns after the edge.
    always @(posedge csi_clk) begin
        logic [39:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pins", {24'h0, user_dataout_0}, {24'h0, e[7:0]});
            chk("readdata", avs_s1_readdata, e[39:8]);
        end
    end

    task automatic step(input logic rst, input logic wr, input logic rd,
                        input logic [3:0] addr, input logic [31:0] wdata);
        csi_reset        = rst;
        avs_s1_write     = wr;
        avs_s1_read      = rd;
        avs_s1_address   = addr;
        avs_s1_writedata = wdata;
        model_edge(rst, wr, rd, addr, wdata);
        @(posedge csi_clk);
        @(negedge csi_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic bus_wr(input logic [3:0] addr, input logic [31:0] wdata);
        step(1'b0, 1'b1, 1'b0, addr, wdata);
    endtask

    task automatic bus_rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
        step(1'b0, 1'b0, 1'b1, addr, 32'h0);
        chk(name, avs_s1_readdata, exp);
    endtask

    task automatic count_pins(input int n, input logic [7:0] val, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            if (user_dataout_0 == val) c++;
        end
    endtask

    initial begin
        int          c;
        int          hi_bit1;
        logic [7:0]  seq;
        logic        rst, wr, rd;
        logic [3:0]  addr;
        logic [31:0] wdata;

        csi_reset        = 1'b1;
        avs_s1_write     = 1'b0;
        avs_s1_read      = 1'b0;
        avs_s1_address   = 4'h0;
        avs_s1_writedata = 32'h0;
        @(negedge csi_clk);

        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        chk("reset_pins", {24'h0, user_dataout_0}, 32'h0);
        chk("reset_rdata", avs_s1_readdata, 32'h0);
        bus_rd_chk("reset_reload", 4'h4, 32'd12_499_999);
        bus_rd_chk("reset_duty", 4'h5, 32'd256);
        bus_rd_chk("reset_mask", 4'h3, 32'h0);

        // Write-to-pin latency
        bus_wr(4'h0, 32'hFFFF_FFA5);
        chk("wr_latency_old", {24'h0, user_dataout_0}, 32'h0);
        idle(1);
        chk("wr_latency_new", {24'h0, user_dataout_0}, 32'hA5);
        bus_rd_chk("data_read", 4'h0, 32'h0000_00A5);

        // Atomic set/clear
        bus_wr(4'h0, 32'hF0);
        bus_wr(4'h1, 32'h0F);
        bus_wr(4'h2, 32'h81);
        bus_rd_chk("setclr_data", 4'h0, 32'h7E);
        bus_rd_chk("setclr_rd_set", 4'h1, 32'h7E);
        bus_rd_chk("setclr_rd_clr", 4'h2, 32'h7E);
        chk("setclr_pins", {24'h0, user_dataout_0}, 32'h7E);

        // Blink with half-period of 4 cycles
        bus_wr(4'h4, 32'd3);
        bus_wr(4'h3, 32'h01);
        bus_wr(4'h0, 32'h03);
        idle(1);
        c = 0;
        hi_bit1 = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (user_dataout_0[0]) c++;
            if (user_dataout_0[1]) hi_bit1++;
        end
        chk("blink_bit0_duty", c, 8);
        chk("blink_bit1_steady", hi_bit1, 16);
        idle(2);
        bus_wr(4'h4, 32'd3);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            seq[i] = user_dataout_0[0];
        end
        chk("blink_restart_seq", {24'h0, seq}, 32'h0F);

        // PWM brightness
        bus_wr(4'h3, 32'h0);
        bus_wr(4'h0, 32'hFF);
        bus_wr(4'h5, 32'd64);
        idle(1);
        count_pins(PWM_PERIOD, 8'hFF, c);
        chk("pwm_64_on", c, 64);
        bus_wr(4'h5, 32'd0);
        idle(1);
        count_pins(PWM_PERIOD, 8'h00, c);
        chk("pwm_0_off", c, PWM_PERIOD);
        bus_wr(4'h5, 32'd256);
        idle(1);
        count_pins(PWM_PERIOD, 8'hFF, c);
        chk("pwm_256_on", c, PWM_PERIOD);

        // Reset wins over a same-cycle write, mid-blink
        bus_wr(4'h4, 32'd2);
        bus_wr(4'h3, 32'hFF);
        idle(5);
        step(1'b1, 1'b1, 1'b1, 4'h0, 32'h11);
        chk("rst_wr_pins", {24'h0, user_dataout_0}, 32'h0);
        chk("rst_wr_rdata", avs_s1_readdata, 32'h0);
        bus_rd_chk("rst_wr_data", 4'h0, 32'h0);
        bus_rd_chk("rst_wr_mask", 4'h3, 32'h0);
        bus_rd_chk("rst_wr_reload", 4'h4, 32'd12_499_999);
        bus_wr(4'h0, 32'h3C);
        idle(1);
        chk("post_rst_pins", {24'h0, user_dataout_0}, 32'h3C);

        // Unmapped address and read-during-write
        bus_wr(4'h0, 32'h55);
        step(1'b0, 1'b1, 1'b1, 4'h0, 32'hAA);
        chk("rdwr_old_value", avs_s1_readdata, 32'h55);
        bus_rd_chk("rdwr_new_value", 4'h0, 32'hAA);
        bus_wr(4'h9, 32'hFFFF_FFFF);
        bus_rd_chk("unmapped_read", 4'h9, 32'h0);
        bus_rd_chk("unmapped_no_side_effect", 4'h0, 32'hAA);

        // Random traffic; the scoreboard checks every edge
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            wr    = ($urandom_range(0, 2) == 0);
            rd    = ($urandom_range(0, 1) == 0);
            addr  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 5));
            wdata = $urandom;
            if (addr == 4'h4) wdata = $urandom_range(0, 9);
            if (addr == 4'h5) wdata = $urandom_range(0, 300);
            step(rst, wr, rd, addr, wdata);
        end
        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
